// File: rtl/riscv_trap_ctrl_if.sv
// Core-side signal bundle for the machine-mode trap controller.
// The slave modport is the controller; the master modport is the pipeline/interrupt side.
interface riscv_trap_ctrl_if #(
   parameter int unsigned MXLEN = 32
);
   logic             irq_i;
   logic             exc_i;
   logic [MXLEN-1:0] cause_i;
   logic [MXLEN-1:0] pc_i;
   logic             mret_i;
   logic             csr_we_i;
   logic [11:0]      csr_addr_i;
   logic [MXLEN-1:0] csr_wdata_i;
   logic [MXLEN-1:0] csr_rdata_o;
   logic             irq_rst_o;
   logic             flush_o;
   logic             stall_o;
   logic             redirect_o;
   logic [MXLEN-1:0] redirect_pc_o;
   logic             mie_o;

   modport master (
      output irq_i, exc_i, cause_i, pc_i, mret_i, csr_we_i, csr_addr_i, csr_wdata_i,
      input  csr_rdata_o, irq_rst_o, flush_o, stall_o, redirect_o, redirect_pc_o, mie_o
   );

   modport slave (
      input  irq_i, exc_i, cause_i, pc_i, mret_i, csr_we_i, csr_addr_i, csr_wdata_i,
      output csr_rdata_o, irq_rst_o, flush_o, stall_o, redirect_o, redirect_pc_o, mie_o
   );
endinterface

// File: rtl/riscv_trap_ctrl.sv
// Machine-mode trap controller: takes exceptions/interrupts, sequences flush and redirect,
// handles mret, and owns mstatus.MIE/MPIE, mtvec, mepc and mcause.
module riscv_trap_ctrl #(
   parameter int unsigned      MXLEN     = 32,
   parameter logic [MXLEN-1:0] MTVEC_RST = MXLEN'(32'h0000_0100)
) (
   input logic             clk_i,
   input logic             rst_i,
   riscv_trap_ctrl_if.slave core
);

   localparam logic [11:0] CsrMstatus = 12'h300;
   localparam logic [11:0] CsrMtvec   = 12'h305;
   localparam logic [11:0] CsrMepc    = 12'h341;
   localparam logic [11:0] CsrMcause  = 12'h342;

   typedef enum logic [1:0] {StIdle, StTrap, StRedirect, StRet} state_e;

   state_e           state_q, state_d;
   logic             mie_q, mie_d;
   logic             mpie_q, mpie_d;
   logic [MXLEN-1:0] mtvec_q, mtvec_d;
   logic [MXLEN-1:0] mepc_q, mepc_d;
   logic [MXLEN-1:0] mcause_q, mcause_d;

   logic             flush, stall, redirect, irq_rst;
   logic [MXLEN-1:0] redirect_pc;
   logic [MXLEN-1:0] base, target;
   logic [MXLEN-1:0] rdata;

   // Vectored mode applies to interrupts only; 4*cause wraps modulo 2^MXLEN.
   always_comb begin
      base   = {mtvec_q[MXLEN-1:2], 2'b00};
      target = base;
      if (mtvec_q[0] && mcause_q[MXLEN-1]) begin
         target = base + {mcause_q[MXLEN-3:0], 2'b00};
      end
   end

   always_comb begin
      rdata = '0;
      case (core.csr_addr_i)
         CsrMstatus: begin
            rdata[3] = mie_q;
            rdata[7] = mpie_q;
         end
         CsrMtvec:  rdata = mtvec_q;
         CsrMepc:   rdata = mepc_q;
         CsrMcause: rdata = mcause_q;
         default:   rdata = '0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      mie_d       = mie_q;
      mpie_d      = mpie_q;
      mtvec_d     = mtvec_q;
      mepc_d      = mepc_q;
      mcause_d    = mcause_q;
      flush       = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      irq_rst     = 1'b0;
      redirect_pc = '0;

      if (core.csr_we_i) begin
         case (core.csr_addr_i)
            CsrMstatus: begin
               mie_d  = core.csr_wdata_i[3];
               mpie_d = core.csr_wdata_i[7];
            end
            CsrMtvec:  mtvec_d  = core.csr_wdata_i & ~MXLEN'(2);
            CsrMepc:   mepc_d   = core.csr_wdata_i & ~MXLEN'(3);
            CsrMcause: mcause_d = core.csr_wdata_i;
            default:   ;
         endcase
      end

      // Trap capture and RET update are assigned after the CSR write so they take precedence.
      case (state_q)
         StIdle: begin
            if (core.exc_i || (core.irq_i && mie_q)) begin
               state_d  = StTrap;
               mepc_d   = core.pc_i & ~MXLEN'(3);
               mcause_d = core.cause_i;
               mpie_d   = mie_q;
               mie_d    = 1'b0;
            end else if (core.mret_i) begin
               state_d = StRet;
            end
         end
         StTrap: begin
            flush   = 1'b1;
            stall   = 1'b1;
            state_d = StRedirect;
         end
         StRedirect: begin
            redirect    = 1'b1;
            redirect_pc = target;
            irq_rst     = mcause_q[MXLEN-1];
            state_d     = StIdle;
         end
         StRet: begin
            flush       = 1'b1;
            redirect    = 1'b1;
            redirect_pc = mepc_q;
            mie_d       = mpie_q;
            mpie_d      = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         mie_q    <= 1'b0;
         mpie_q   <= 1'b0;
         mtvec_q  <= MTVEC_RST;
         mepc_q   <= '0;
         mcause_q <= '0;
      end else begin
         state_q  <= state_d;
         mie_q    <= mie_d;
         mpie_q   <= mpie_d;
         mtvec_q  <= mtvec_d;
         mepc_q   <= mepc_d;
         mcause_q <= mcause_d;
      end
   end

   // Reset masks outputs immediately so an in-flight trap never redirects.
   assign core.csr_rdata_o   = rdata;
   assign core.flush_o       = flush & ~rst_i;
   assign core.stall_o       = stall & ~rst_i;
   assign core.redirect_o    = redirect & ~rst_i;
   assign core.irq_rst_o     = irq_rst & ~rst_i;
   assign core.redirect_pc_o = rst_i ? '0 : redirect_pc;
   assign core.mie_o         = mie_q & ~rst_i;

endmodule
